seq_stream_buffer: RTL and testbench

SEQ_STREAM_BUFFER -- requirements
Module: seq_stream_buffer

---
 rtl/seq_stream_buffer.sv | 127 ++++++++++++
 tb/tb_seq_stream_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_buffer.sv
// Single-clock FIFO stream buffer with occupancy FSM and sticky statistics
// (overflow flag, drop counter, odd-word counter, running unsigned maximum).
module seq_stream_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                odd_cnt,
  output logic [WIDTH-1:0]           max_val
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_e;

  occ_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]       odd_cnt_q, odd_cnt_d;
  logic [WIDTH-1:0]  max_val_q, max_val_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic push, pop, drop;

  // Handshake flags come straight from the registered state, so in_ready
  // never depends on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign odd_cnt   = odd_cnt_q;
  assign max_val   = max_val_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    odd_cnt_d  = odd_cnt_q;
    max_val_d  = max_val_q;
    state_d    = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (in_data[0] && odd_cnt_q != 16'hFFFF) odd_cnt_d = odd_cnt_q + 16'd1;
      if (in_data > max_val_q) max_val_d = in_data;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    unique case (state_q)
      ST_EMPTY:   if (push) state_d = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push && !pop && count_q == CNT_LAST) state_d = ST_FULL;
        else if (pop && !push && count_q == (AW+1)'(1)) state_d = ST_EMPTY;
      end
      ST_FULL:    if (pop) state_d = ST_PARTIAL;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      odd_cnt_q  <= '0;
      max_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      odd_cnt_q  <= odd_cnt_d;
      max_val_q  <= max_val_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= in_data;
  end

  // Full count is only reachable through the FULL state.
  logic unused_full_cmp;
  assign unused_full_cmp = (count_q == CNT_FULL);

endmodule

// File: tb/tb_seq_stream_buffer.sv
// Directed bench for seq_stream_buffer: table-driven fill/overflow/drain,
// plus hand-written streaming, mid-operation reset and saturation sequences.
module tb_seq_stream_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [3:0]        count;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic [15:0]       odd_cnt;
  logic [WIDTH-1:0]  max_val;

  int checks = 0;
  int errors = 0;

  seq_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .odd_cnt   (odd_cnt),
    .max_val   (max_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic [3:0]  exp_count;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [15:0] exp_out_data;
    logic        exp_overflow;
    logic [15:0] exp_drop;
    logic [15:0] exp_odd;
    logic [15:0] exp_max;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input logic [3:0] c, input logic ov,
                             input logic [15:0] dr, input logic [15:0] od, input logic [15:0] mx);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dr));
    check({tag, ".odd_cnt"}, 32'(odd_cnt), 32'(od));
    check({tag, ".max_val"}, 32'(max_val), 32'(mx));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // (a) fill, (b) overflow, (c) drain: state expected after each edge
    vecs[0]  = '{1, 16'd1,  0, 4'd1, 1, 1, 16'd1,  0, 16'd0, 16'd1, 16'd1};
    vecs[1]  = '{1, 16'd2,  0, 4'd2, 1, 1, 16'd1,  0, 16'd0, 16'd1, 16'd2};
    vecs[2]  = '{1, 16'd4,  0, 4'd3, 1, 1, 16'd1,  0, 16'd0, 16'd1, 16'd4};
    vecs[3]  = '{1, 16'd7,  0, 4'd4, 1, 1, 16'd1,  0, 16'd0, 16'd2, 16'd7};
    vecs[4]  = '{1, 16'd14, 0, 4'd5, 1, 1, 16'd1,  0, 16'd0, 16'd2, 16'd14};
    vecs[5]  = '{1, 16'd19, 0, 4'd6, 1, 1, 16'd1,  0, 16'd0, 16'd3, 16'd19};
    vecs[6]  = '{1, 16'd38, 0, 4'd7, 1, 1, 16'd1,  0, 16'd0, 16'd3, 16'd38};
    vecs[7]  = '{1, 16'd45, 0, 4'd8, 0, 1, 16'd1,  0, 16'd0, 16'd4, 16'd45};
    vecs[8]  = '{1, 16'd90, 0, 4'd8, 0, 1, 16'd1,  1, 16'd1, 16'd4, 16'd45};
    vecs[9]  = '{0, 16'd0,  1, 4'd7, 1, 1, 16'd2,  1, 16'd1, 16'd4, 16'd45};
    vecs[10] = '{0, 16'd0,  1, 4'd6, 1, 1, 16'd4,  1, 16'd1, 16'd4, 16'd45};
    vecs[11] = '{0, 16'd0,  1, 4'd5, 1, 1, 16'd7,  1, 16'd1, 16'd4, 16'd45};
    vecs[12] = '{0, 16'd0,  1, 4'd4, 1, 1, 16'd14, 1, 16'd1, 16'd4, 16'd45};
    vecs[13] = '{0, 16'd0,  1, 4'd3, 1, 1, 16'd19, 1, 16'd1, 16'd4, 16'd45};
    vecs[14] = '{0, 16'd0,  1, 4'd2, 1, 1, 16'd38, 1, 16'd1, 16'd4, 16'd45};
    vecs[15] = '{0, 16'd0,  1, 4'd1, 1, 1, 16'd45, 1, 16'd1, 16'd4, 16'd45};
    vecs[16] = '{0, 16'd0,  1, 4'd0, 1, 0, 16'd0,  1, 16'd1, 16'd4, 16'd45};
    vecs[17] = '{0, 16'd0,  1, 4'd0, 1, 0, 16'd0,  1, 16'd1, 16'd4, 16'd45};

    do_reset();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_stats("rst", 4'd0, 1'b0, 16'd0, 16'd0, 16'd0);

    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      in_valid = vecs[i].in_valid; in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      step();
      check({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].exp_in_ready));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(vecs[i].exp_out_valid));
      if (vecs[i].exp_out_valid)
        check({tag, ".out_data"}, 32'(out_data), 32'(vecs[i].exp_out_data));
      check_stats(tag, vecs[i].exp_count, vecs[i].exp_overflow, vecs[i].exp_drop,
                  vecs[i].exp_odd, vecs[i].exp_max);
    end

    // (d) streaming at occupancy 3: words 100.. go in, come out in order
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(100 + i); out_ready = 1'b0;
      step();
    end
    check("stream.prefill_count", 32'(count), 32'd3);
    check("stream.prefill_head", 32'(out_data), 32'd100);
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1; in_data = 16'(103 + j); out_ready = 1'b1;
      step();
      check($sformatf("stream%0d.count", j), 32'(count), 32'd3);
      check($sformatf("stream%0d.head", j), 32'(out_data), 32'(101 + j));
    end
    // odd words among 100..122: 101,103,...,121
    check_stats("stream.end", 4'd3, 1'b0, 16'd0, 16'd11, 16'd122);

    // (e) reset with count = 5, push offered on the reset edge too
    in_valid = 1'b1; in_data = 16'd200; out_ready = 1'b0;
    step();
    in_data = 16'd201;
    step();
    check("midrst.pre_count", 32'(count), 32'd5);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'd301; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check_stats("midrst", 4'd0, 1'b0, 16'd0, 16'd0, 16'd0);
    step();
    check("midrst.idle_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 16'h0055;
    step();
    in_valid = 1'b0;
    check("midrst.first_valid", 32'(out_valid), 32'd1);
    check("midrst.first_data", 32'(out_data), 32'h55);
    check("midrst.first_count", 32'(count), 32'd1);

    // Push+pop while full: pop happens, the offered word is dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 16'(2 * i); step();
    end
    in_valid = 1'b1; in_data = 16'd999; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpp.head", 32'(out_data), 32'd2);
    check_stats("fullpp", 4'd7, 1'b1, 16'd1, 16'd0, 16'd14);

    // (f) odd_cnt saturation
    do_reset();
    in_valid = 1'b1; in_data = 16'd1; out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    check("sat.odd_65534", 32'(odd_cnt), 32'hFFFE);
    step();
    check("sat.odd_65535", 32'(odd_cnt), 32'hFFFF);
    step();
    check("sat.odd_65536", 32'(odd_cnt), 32'hFFFF);
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("sat.odd_hold", 32'(odd_cnt), 32'hFFFF);
    check_stats("sat.end", 4'd1, 1'b0, 16'd0, 16'hFFFF, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
